// File: rtl/even_odd_sort.sv
// Fully pipelined Batcher odd-even merge sorting network, one register rank per comparator stage.
// Define EVEN_ODD_DESCEND_EN to sort descending (key 0 largest) instead of ascending.
module even_odd_sort #(
   parameter int unsigned P_LOG = 7,
   parameter int unsigned WIDTH = 32
) (
   input  logic                         CLK,
   input  logic                         RST,
   input  logic [WIDTH*(1<<P_LOG)-1:0]  DIN,
   input  logic                         DINEN,
   output logic [WIDTH*(1<<P_LOG)-1:0]  DOT,
   output logic                         DOTEN
);

   localparam int unsigned N = 1 << P_LOG;
   localparam int unsigned S = P_LOG * (P_LOG + 1) / 2;

   typedef logic [N-1:0][WIDTH-1:0] vec_t;

   vec_t         st_in  [S];
   vec_t         st_out [S];
   vec_t         rank_q [S];
   logic [S-1:0] vld_q;
   logic [S-1:0] vld_d;

   // True when key x is the lo side of a compare-exchange in the step with merge span p, distance k.
   function automatic logic is_lo(input int x, input int p, input int k, input int n);
      int off;
      off = k % p;
      if (x < off)                     return 1'b0;
      if (x + k >= n)                  return 1'b0;
      if (((x - off) % (2 * k)) >= k)  return 1'b0;
      return ((x / (2 * p)) == ((x + k) / (2 * p)));
   endfunction

   function automatic logic [WIDTH-1:0] sel_lo(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
`ifdef EVEN_ODD_DESCEND_EN
      return (a > b) ? a : b;
`else
      return (a < b) ? a : b;
`endif
   endfunction

   function automatic logic [WIDTH-1:0] sel_hi(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
`ifdef EVEN_ODD_DESCEND_EN
      return (a > b) ? b : a;
`else
      return (a < b) ? b : a;
`endif
   endfunction

   for (genvar s = 0; s < S; s++) begin : g_in
      if (s == 0) begin : g_first
         assign st_in[s] = DIN;
      end else begin : g_chain
         assign st_in[s] = rank_q[s-1];
      end
   end

   // Merge phase a doubles sorted run length; step b halves compare distance within it.
   for (genvar a = 0; a < P_LOG; a++) begin : g_merge
      for (genvar b = 0; b <= a; b++) begin : g_step
         localparam int SI = a * (a + 1) / 2 + b;
         localparam int P  = 1 << a;
         localparam int K  = P >> b;
         for (genvar x = 0; x < N; x++) begin : g_key
            localparam logic LO = is_lo(x, P, K, N);
            localparam logic HI = is_lo(x - K, P, K, N);
            if (LO) begin : g_lo
               assign st_out[SI][x] = sel_lo(st_in[SI][x], st_in[SI][x+K]);
            end else if (HI) begin : g_hi
               assign st_out[SI][x] = sel_hi(st_in[SI][x-K], st_in[SI][x]);
            end else begin : g_pass
               assign st_out[SI][x] = st_in[SI][x];
            end
         end
      end
   end

   always_comb begin
      vld_d    = vld_q << 1;
      vld_d[0] = DINEN;
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         for (int s = 0; s < S; s++) rank_q[s] <= '0;
         vld_q <= '0;
      end else begin
         for (int s = 0; s < S; s++) rank_q[s] <= st_out[s];
         vld_q <= vld_d;
      end
   end

   assign DOT   = rank_q[S-1];
   assign DOTEN = vld_q[S-1];

endmodule

// File: tb/tb_even_odd_sort.sv
// Directed self-checking bench for even_odd_sort: a 128x32 instance and a 4x8 instance.
module tb_even_odd_sort;

   localparam int N  = 128;
   localparam int W  = 32;
   localparam int S  = 28;
   localparam int SN = 4;
   localparam int SW = 8;
   localparam int SS = 3;

   typedef logic [N-1:0][W-1:0]   vec_t;
   typedef logic [SN-1:0][SW-1:0] svec_t;

   logic CLK = 1'b0;
   always #5 CLK = ~CLK;

   logic           RST;
   logic [N*W-1:0] din, dot;
   logic           dinen, doten;
   logic [SN*SW-1:0] sdin, sdot;
   logic           sdinen, sdoten;

   int n_cmp = 0;
   int n_bad = 0;

   even_odd_sort #(.P_LOG(7), .WIDTH(32)) u_dut (
      .CLK(CLK), .RST(RST), .DIN(din), .DINEN(dinen), .DOT(dot), .DOTEN(doten)
   );

   even_odd_sort #(.P_LOG(2), .WIDTH(8)) u_small (
      .CLK(CLK), .RST(RST), .DIN(sdin), .DINEN(sdinen), .DOT(sdot), .DOTEN(sdoten)
   );

   // Expected output for a vector whose ascending sort is asc.
   function automatic vec_t order(input vec_t asc);
      vec_t r;
`ifdef EVEN_ODD_DESCEND_EN
      for (int i = 0; i < N; i++) r[i] = asc[N-1-i];
`else
      r = asc;
`endif
      return r;
   endfunction

   function automatic vec_t ramp();
      vec_t r;
      for (int i = 0; i < N; i++) r[i] = W'(i + 1);
      return r;
   endfunction

   function automatic int first_diff(input vec_t a, input vec_t b);
      for (int i = 0; i < N; i++) if (a[i] !== b[i]) return i;
      return 0;
   endfunction

   task automatic wait_doten(output int cnt);
      cnt = 0;
      while (doten !== 1'b1 && cnt < 60) begin
         @(posedge CLK); #1;
         cnt++;
      end
   endtask

   task automatic send(input vec_t v);
      din   = v;
      dinen = 1'b1;
      @(posedge CLK); #1;
      dinen = 1'b0;
      din   = '1;
   endtask

   task automatic test_reset();
      RST = 1'b0; din = '0; dinen = 1'b0; sdin = '0; sdinen = 1'b0;
      #12;
      n_cmp++; if (doten !== 1'b0) begin n_bad++; $display("FAIL reset_doten got %b want 0", doten); end
      n_cmp++; if (dot !== '0) begin n_bad++; $display("FAIL reset_dot got nonzero want 0"); end
      n_cmp++; if (sdoten !== 1'b0) begin n_bad++; $display("FAIL reset_sdoten got %b want 0", sdoten); end
      n_cmp++; if (sdot !== '0) begin n_bad++; $display("FAIL reset_sdot got %h want 0", sdot); end
      @(posedge CLK); #1;
      RST = 1'b1;
      @(posedge CLK); #1;
   endtask

   task automatic check_vec(input string name, input vec_t exp);
      vec_t got;
      int   d;
      got = dot;
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         d = first_diff(got, exp);
         $display("FAIL %s key %0d got %h want %h", name, d, got[d], exp[d]);
      end
   endtask

   task automatic check_lat(input string name, input int cnt, input int want);
      n_cmp++;
      if (cnt !== want) begin n_bad++; $display("FAIL %s latency got %0d want %0d", name, cnt, want); end
   endtask

   task automatic test_reversed();
      vec_t v;
      int   cnt;
      for (int i = 0; i < N; i++) v[i] = W'(N - i);
      send(v);
      wait_doten(cnt);
      check_lat("reversed", cnt, S - 1);
      check_vec("reversed_data", order(ramp()));
      @(posedge CLK); #1;
      n_cmp++; if (doten !== 1'b0) begin n_bad++; $display("FAIL single_pulse got %b want 0", doten); end
   endtask

   task automatic test_sorted_input();
      int cnt;
      send(ramp());
      wait_doten(cnt);
      check_lat("sorted", cnt, S - 1);
      check_vec("sorted_data", order(ramp()));
      @(posedge CLK); #1;
   endtask

   task automatic test_back_to_back();
      vec_t v [3];
      int   cnt;
      for (int i = 0; i < N; i++) begin
         v[0][i] = W'(N - i);
         v[1][i] = W'(i + 1);
         v[2][i] = W'(((i * 37 + 11) % N) + 1);
      end
      for (int j = 0; j < 3; j++) begin
         din = v[j]; dinen = 1'b1;
         @(posedge CLK); #1;
      end
      dinen = 1'b0; din = '0;
      wait_doten(cnt);
      check_lat("b2b", cnt, S - 3);
      for (int j = 0; j < 3; j++) begin
         n_cmp++; if (doten !== 1'b1) begin n_bad++; $display("FAIL b2b_valid%0d got %b want 1", j, doten); end
         check_vec($sformatf("b2b_data%0d", j), order(ramp()));
         @(posedge CLK); #1;
      end
      n_cmp++; if (doten !== 1'b0) begin n_bad++; $display("FAIL b2b_tail got %b want 0", doten); end
   endtask

   task automatic test_dup_extremes();
      vec_t v, asc;
      int   cnt;
      v[0] = 32'hFFFF_FFFF; v[1] = 32'd5; v[2] = 32'd0; v[3] = 32'd5; v[4] = 32'd5;
      for (int i = 5; i < N; i++) v[i] = W'(232 - i);
      asc[0] = 32'd0;
      for (int i = 1; i < 4; i++) asc[i] = 32'd5;
      for (int i = 4; i < N - 1; i++) asc[i] = W'(101 + i);
      asc[N-1] = 32'hFFFF_FFFF;
      send(v);
      wait_doten(cnt);
      check_lat("dup", cnt, S - 1);
      check_vec("dup_data", order(asc));
      @(posedge CLK); #1;
   endtask

   task automatic test_reset_midflight();
      vec_t v;
      int   cnt, pulses;
      for (int i = 0; i < N; i++) v[i] = W'(N - i);
      send(v);
      repeat (8) begin @(posedge CLK); #1; end
      RST = 1'b0;
      #1;
      n_cmp++; if (doten !== 1'b0) begin n_bad++; $display("FAIL midrst_doten got %b want 0", doten); end
      n_cmp++; if (dot !== '0) begin n_bad++; $display("FAIL midrst_dot got nonzero want 0"); end
      repeat (2) @(posedge CLK);
      #1;
      RST = 1'b1;
      pulses = 0;
      repeat (40) begin
         @(posedge CLK); #1;
         if (doten === 1'b1) pulses++;
      end
      n_cmp++; if (pulses !== 0) begin n_bad++; $display("FAIL midrst_ghost got %0d pulses want 0", pulses); end
      send(v);
      wait_doten(cnt);
      check_lat("midrst_new", cnt, S - 1);
      check_vec("midrst_data", order(ramp()));
      @(posedge CLK); #1;
   endtask

   task automatic test_small();
      svec_t v, exp;
      int    cnt;
      for (int i = 0; i < SN; i++) begin
         v[i] = SW'(SN - i);
`ifdef EVEN_ODD_DESCEND_EN
         exp[i] = SW'(SN - i);
`else
         exp[i] = SW'(i + 1);
`endif
      end
      sdin = v; sdinen = 1'b1;
      @(posedge CLK); #1;
      sdinen = 1'b0; sdin = '0;
      cnt = 0;
      while (sdoten !== 1'b1 && cnt < 20) begin
         @(posedge CLK); #1;
         cnt++;
      end
      check_lat("small", cnt, SS - 1);
      n_cmp++; if (sdot !== exp) begin n_bad++; $display("FAIL small_data got %h want %h", sdot, exp); end
      @(posedge CLK); #1;
   endtask

   initial begin
      test_reset();
      test_reversed();
      test_sorted_input();
      test_back_to_back();
      test_dup_extremes();
      test_reset_midflight();
      test_small();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
